wb_dest_scoreboard: RTL
=======================

# wb_dest_scoreboard

Tracks in-flight register writes for the 16-bit RISC pipeline's 8-entry register file (3-bit register addresses). The issue side presents destination and source register addresses and is stalled on RAW hazards or pending-count saturation. The writeback side presents a 3-bit destination address, which the block decodes into a registered one-hot register-file write enable while retiring the pending write. It sits between decode/issue and the register file write port, and consumes the 3-bit address that the destination-select mux produces.

## Interface
- NREGS, 8, register count; fixed at 8 (3-bit addresses).
- CNT_W, 2, pending-write counter width per register; max outstanding writes per register = 2^CNT_W - 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  instruction presented for issue.
- issue_wr  in  1  instruction writes a register.
- issue_rd  in  3  destination register.
- issue_rs1  in  3  source register 1.
- issue_rs1_en  in  1  rs1 is read.
- issue_rs2  in  3  source register 2.
- issue_rs2_en  in  1  rs2 is read.
- issue_ready  out  1  combinational; the issue is accepted this cycle when issue_valid && issue_ready.
- wb_valid  in  1  writeback presented; always accepted.
- wb_rd  in  3  writeback destination register.
- rf_we  out  8  registered one-hot register-file write enable.
- busy  out  8  registered; busy[i] = (pend[i] != 0).
- err_underflow  out  1  sticky error flag; cleared only by rst.

## Operation
- State: pend[0..7], each CNT_W bits wide; err_underflow.
- issue_ready = !(rs1_hazard || rs2_hazard || rd_full).
  - rs1_hazard = issue_rs1_en && pend[issue_rs1] != 0.
  - rs2_hazard: same rule for rs2.
  - rd_full = issue_wr && pend[issue_rd] == max.
- issue_ready depends only on the current pend values. A same-cycle writeback does not unstall the issue; there is no bypass.
- Accepted issue with issue_wr=1 increments pend[issue_rd]. An accepted issue with issue_wr=0 changes no state.
- wb_valid with pend[wb_rd] != 0 decrements pend[wb_rd]. The next cycle, rf_we = 1 << wb_rd.
- wb_valid with pend[wb_rd] == 0:
  - pend stays 0 (no wrap).
  - err_underflow is set.
  - rf_we is still driven (the write is not suppressed).
- Simultaneous accepted issue-write and writeback to the same register: pend is unchanged, and rf_we still fires.
- Simultaneous events on different registers: both updates apply independently.
- When there is no wb_valid, rf_we = 0 the following cycle.
- Reset values: all pend = 0, rf_we = 0, busy = 0, err_underflow = 0. After reset, issue_ready = 1 for any input.

## Timing
- issue_ready: zero-latency combinational path from issue_* and pend.
- pend update: one edge after acceptance. busy reflects the new count in the same cycle pend updates.
- rf_we: exactly 1 cycle after wb_valid, and high for 1 cycle per writeback. Back-to-back writebacks give back-to-back one-hot pulses.
- Reset mid-operation: rst takes priority over every concurrent issue or writeback in that cycle. All outstanding counts are discarded, and rf_we is 0 the cycle after rst.
- Throughput: 1 issue plus 1 writeback per cycle.

## Structure
- Shared package `risc_pkg`:
  - REG_ADDR_W = 3.
  - NREGS = 8.
  - typedef reg_addr_t (3-bit).
  - typedef reg_onehot_t (8-bit).
- Sub-module `reg_addr_decoder`: combinational 3-to-8 one-hot decode with an enable input, shared with the register file read side.
- Top level contains:
  - the pend counter array, with saturating increment/decrement logic;
  - the hazard logic;
  - the rf_we output register.

## Test plan
- Reset → rf_we=00, busy=00, err_underflow=0; issue_ready=1 with rs1_en=rs2_en=1 on R3,R5.
- RAW stall:
  - Issue wr R2 accepted → busy=04.
  - Next cycle, issue rs1=R2 → issue_ready=0.
  - wb_rd=R2 → rf_we=04 the next cycle, busy=00, then issue_ready=1.
- Saturation (CNT_W=2):
  - Three writes to R7 accepted → pend[7]=3.
  - A fourth write to R7 → issue_ready=0 until a writeback to R7.
- Same-cycle issue-write R4 and writeback R4 with pend[4]=1 → pend[4] stays 1, busy[4]=1, rf_we=10 the next cycle.
- Underflow: wb_rd=R1 with pend[1]=0 → rf_we=02, err_underflow=1 and stays set; pend[1]=0.
- Reset mid-stream with pend[2]=2 and wb_valid active → the next cycle busy=00, rf_we=00, err_underflow=0.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC pipeline register-file datapath.
// Holds the register address width, register count and the address and
// one-hot enable types used by decode, the scoreboard and the register file.
package risc_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int NREGS      = 8;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [NREGS-1:0]      reg_onehot_t;

endpackage

// File: rtl/wb_dest_scoreboard_if.sv
// Issue and writeback bus between the pipeline and wb_dest_scoreboard.
//   master : pipeline side; drives issue_* and wb_*, receives issue_ready.
//   slave  : scoreboard side.
// Handshake: an issue is accepted on a clock edge where
// issue_valid && issue_ready. issue_ready may depend combinationally on the
// issue_* fields and must not be used to decide issue_valid. A writeback has
// no ready; it is taken on every edge where wb_valid is high.
interface wb_dest_scoreboard_if;
  import risc_pkg::*;

  logic      issue_valid;
  logic      issue_wr;
  reg_addr_t issue_rd;
  reg_addr_t issue_rs1;
  logic      issue_rs1_en;
  reg_addr_t issue_rs2;
  logic      issue_rs2_en;
  logic      issue_ready;
  logic      wb_valid;
  reg_addr_t wb_rd;

  modport master (
    output issue_valid, issue_wr, issue_rd, issue_rs1, issue_rs1_en,
           issue_rs2, issue_rs2_en, wb_valid, wb_rd,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_wr, issue_rd, issue_rs1, issue_rs1_en,
           issue_rs2, issue_rs2_en, wb_valid, wb_rd,
    output issue_ready
  );

endinterface

// File: rtl/reg_addr_decoder.sv
// Combinational 3-to-8 one-hot register address decoder with enable.
// Shared by the scoreboard and the register file read side.
//   en     : when low the output is all zeros
//   addr   : register address
//   onehot : 1 << addr when en, else 0
module reg_addr_decoder
  import risc_pkg::*;
(
  input  logic        en,
  input  reg_addr_t   addr,
  output reg_onehot_t onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/wb_dest_scoreboard.sv
// Destination-register scoreboard. Counts outstanding writes per register,
// stalls issue on RAW hazards or when a register's pending counter is full,
// and turns each writeback into a registered one-hot register-file write
// enable.
//   clk, rst      : clock, synchronous active-high reset
//   bus           : issue/writeback bus (slave side)
//   rf_we         : registered one-hot write enable, one cycle after wb_valid
//   busy          : registered, busy[i] = pending count of register i != 0
//   err_underflow : sticky, set by a writeback to a register with no pending
//                   write; cleared only by rst
module wb_dest_scoreboard
  import risc_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  wb_dest_scoreboard_if.slave        bus,
  output reg_onehot_t                rf_we,
  output reg_onehot_t                busy,
  output logic                       err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] pend      [NREGS];
  logic [CNT_W-1:0] pend_next [NREGS];

  logic        rs1_hazard;
  logic        rs2_hazard;
  logic        rd_full;
  logic        ready;
  logic        issue_accept;
  logic        underflow;
  reg_onehot_t inc_vec;
  reg_onehot_t wb_vec;

  // Hazards look only at the registered counts: a writeback in the same
  // cycle does not release a stalled issue (no bypass).
  assign rs1_hazard   = bus.issue_rs1_en && (pend[bus.issue_rs1] != '0);
  assign rs2_hazard   = bus.issue_rs2_en && (pend[bus.issue_rs2] != '0);
  assign rd_full      = bus.issue_wr && (pend[bus.issue_rd] == CNT_MAX);
  assign ready        = !(rs1_hazard || rs2_hazard || rd_full);
  assign bus.issue_ready = ready;
  assign issue_accept = bus.issue_valid && ready;

  assign underflow = bus.wb_valid && (pend[bus.wb_rd] == '0);

  reg_addr_decoder u_inc_dec (
    .en     (issue_accept && bus.issue_wr),
    .addr   (bus.issue_rd),
    .onehot (inc_vec)
  );

  reg_addr_decoder u_wb_dec (
    .en     (bus.wb_valid),
    .addr   (bus.wb_rd),
    .onehot (wb_vec)
  );

  // Per-register saturating counter. Issue-write and writeback to the same
  // register cancel out and leave the count as it was.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      pend_next[i] = pend[i];
      if (inc_vec[i] && !wb_vec[i] && pend[i] != CNT_MAX)
        pend_next[i] = pend[i] + CNT_W'(1);
      else if (!inc_vec[i] && wb_vec[i] && pend[i] != '0)
        pend_next[i] = pend[i] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) pend[i] <= '0;
      rf_we         <= '0;
      busy          <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        pend[i] <= pend_next[i];
        busy[i] <= (pend_next[i] != '0);
      end
      // The write enable is never suppressed, even on underflow.
      rf_we <= wb_vec;
      if (underflow) err_underflow <= 1'b1;
    end
  end

endmodule
